mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit datapath between four requesters. It uses a 4:1 select to route them onto the shared bus. Each requester uses a req/gnt handshake. The block drives the mux select, the one-hot grants and a registered output word with a valid strobe. It sits in front of any shared write port or bus in the processor datapath where more than one source competes for the same destination.

## Interface
- WIDTH, 8: data width of each requester word and of y.
- MAX_HOLD, 4: max consecutive grant cycles for one owner while another requester waits. Must be ≥1.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  4  request per requester; held high while it wants the bus.
- d0, d1, d2, d3  in  WIDTH each  requester data words.
- gnt  out  4  registered one-hot grant; all-zero when idle.
- sel  out  2  registered binary index of the current owner; drives the mux select.
- y  out  WIDTH  registered word captured from the owner.
- y_valid  out  1  high for one cycle per captured word.

## Operation
- FSM with two states: IDLE and GRANT.
- Registers: owner index, last-granted pointer `last` (2 bits), and `hold_cnt` of width clog2(MAX_HOLD+1).
- Rotation order: search starts at last+1 mod 4 and wraps to last. The first set req wins.
- IDLE:
  - If req==0: stay in IDLE, gnt=0.
  - Else grant the rotation winner: gnt=onehot(w), sel=w, last=w, hold_cnt=1, go to GRANT.
- GRANT with owner i, evaluated at each edge:
  - req[i]==0 and some other req set: hand over to the rotation winner with no idle bubble (last=winner, hold_cnt=1).
  - req[i]==0 and no other req: go to IDLE, gnt=0, sel holds its value.
  - req[i]==1, hold_cnt==MAX_HOLD, and another req set: force rotation to the winner (the winner excludes i because the search starts at i+1).
  - Otherwise keep owner i; hold_cnt increments, saturating at MAX_HOLD.
- A lone requester is never preempted. hold_cnt stays saturated while it is uncontended.
- Data capture at each edge:
  - If gnt[sel]&req[sel]: y <= d[sel], y_valid <= 1.
  - Else y_valid <= 0 and y holds.
- A requester that drops req in the same cycle it is granted gets no capture. The grant is withdrawn at the next edge.
- Reset (reset==0, async): state=IDLE, gnt=0, sel=0, y=0, y_valid=0, hold_cnt=0, last=3 (so requester 0 has first priority). Reset mid-grant aborts immediately. Any word not yet captured is lost.

## Timing
- Grant latency: req rising before edge N gives gnt at edge N (visible in cycle N+1).
- Data latency: d sampled at the first edge where gnt&req are both high. y/y_valid are visible one cycle after that edge.
- Sustained throughput: one word per cycle while the owner holds req.
- Handover costs 0 idle cycles. The new owner's first capture is one edge after its grant.
- Contended worst-case wait: 3×MAX_HOLD cycles.
- All outputs are registered. No combinational path from req or d to any output.

## Structure
- Shared package:
  - NREQ=4.
  - State typedef {IDLE, GRANT}.
  - Reset value of `last` (3).
  - Function onehot2(idx)→4-bit.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and last[1:0]; outputs any and winner[1:0].
- Data selection uses the codebase's mux4 with WIDTH passed through and s=sel.

## Test plan
- Reset then idle: hold reset=0 with req=4'b1111 → gnt=0, sel=0, y=0, y_valid=0. Release reset with req=4'b1111 → gnt=0001 one cycle later.
- Single requester streaming: req=0100, d2=8'hA5 then 8'h3C on successive cycles → gnt=0100, sel=2. y=A5 then 3C with y_valid high both cycles. No preemption after 10 cycles.
- Contention, MAX_HOLD=4: req=0011 held → gnt pattern 0001×4, 0010×4, 0001×4. Each handover has no gnt=0 gap.
- Early release: owner 1 drops req after 2 cycles while req[3]=1 → gnt moves to 1000 at the next edge. hold_cnt restarts at 1.
- Wrap-around: last=3 with req=1001 → requester 0 wins. Then after requester 0 releases → requester 3 wins.
- Async reset mid-grant: assert reset between edges while gnt=0010 → gnt, sel, y and y_valid go to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Purpose  : shared types, constants and helpers for the 4-way round-robin arbiter.
// Latency  : n/a (declarations only).
// Backpress: n/a.
package mux4_rr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Last-granted pointer after reset: the search then starts at requester 0.
    localparam logic [1:0] LAST_RST = 2'd3;

    function automatic logic [NREQ-1:0] onehot2(input logic [1:0] idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Purpose  : bundle of requester handshake, data words and arbitrated output.
// Latency  : n/a (wiring only).
// Backpress: req/gnt handshake; a requester holds req until it has been served.
// Ports: req/d0..d3 driven by requesters, gnt/sel/y/y_valid driven by the arbiter.
interface mux4_rr_arbiter_if
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [NREQ-1:0]  gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    // Requester side.
    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, y, y_valid
    );

    // Arbiter side.
    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, y, y_valid
    );
endinterface

// File: rtl/mux4.sv
// Purpose  : generic 4:1 word multiplexer.
// Latency  : combinational.
// Backpress: none.
// Ports: d0_i..d3_i data inputs, s_i binary select, y_o selected word.
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    input  logic [1:0]       s_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        y_o = d0_i;
        unique case (s_i)
            2'd0: y_o = d0_i;
            2'd1: y_o = d1_i;
            2'd2: y_o = d2_i;
            2'd3: y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Purpose  : round-robin pick among 4 requests, search starting after last_i.
// Latency  : combinational.
// Backpress: none.
// Ports: req_i requests, last_i last-granted index, any_o some request set,
//        winner_o first set request at last+1, last+2, last+3, last (mod 4).
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      last_i,
    output logic            any_o,
    output logic [1:0]      winner_o
);
    logic [1:0] idx;

    always_comb begin
        any_o    = |req_i;
        winner_o = last_i;
        idx      = last_i;
        // Walk from the farthest position back to the nearest so the nearest
        // set request (smallest offset) is the last one written.
        for (int k = NREQ; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Purpose  : round-robin arbiter sharing one WIDTH-bit bus between 4 requesters.
// Latency  : grant one edge after req; data registered one edge after gnt&req.
// Backpress: owner keeps the bus while req is high, preempted after MAX_HOLD
//            cycles only if someone else is waiting.
// Ports: clk, rst_n (async, active-low), bus (slave side of mux4_rr_arbiter_if).
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;

    logic             any_req;
    logic [1:0]       winner;
    logic             others_req;
    logic             owner_req;
    logic [WIDTH-1:0] mux_y;

    // While granted, last_q equals the owner, so the same pick serves both
    // idle arbitration and handover/preemption (the owner is searched last).
    rr_pick4 u_pick (
        .req_i    (bus.req),
        .last_i   (last_q),
        .any_o    (any_req),
        .winner_o (winner)
    );

    mux4 #(.WIDTH(WIDTH)) u_mux (
        .d0_i (bus.d0),
        .d1_i (bus.d1),
        .d2_i (bus.d2),
        .d3_i (bus.d3),
        .s_i  (sel_q),
        .y_o  (mux_y)
    );

    assign owner_req  = bus.req[sel_q];
    assign others_req = |(bus.req & ~onehot2(sel_q));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = onehot2(winner);
                    sel_d   = winner;
                    last_d  = winner;
                    hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (!owner_req && !others_req) begin
                    // Nobody wants the bus: release, sel keeps the last owner.
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (!owner_req || (hold_q == HOLD_MAX && others_req)) begin
                    // Handover without an idle bubble.
                    gnt_d  = onehot2(winner);
                    sel_d  = winner;
                    last_d = winner;
                    hold_d = HOLD_ONE;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Capture only when the current owner is still requesting.
    always_comb begin
        y_d       = y_q;
        y_valid_d = 1'b0;
        if (gnt_q[sel_q] && owner_req) begin
            y_d       = mux_y;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= 2'd0;
            last_q    <= LAST_RST;
            hold_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Purpose  : self-checking bench for mux4_rr_arbiter (WIDTH=8, MAX_HOLD=4).
// Latency  : outputs sampled 1 time unit after each rising edge.
// Backpress: captured words are checked in order against an expected-word queue.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    logic clk;
    logic rst_n;

    mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];
    logic [3:0] exp_gnt [12];
    logic [7:0] wrd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: wait for the edge, settle, then score any captured word.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.y_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_y_valid", 32'(bus.y), 32'hFFFF_FFFF);
            end else begin
                chk("y_word", 32'(bus.y), 32'(sb_q.pop_front()));
            end
        end
    endtask

    task automatic drain_check(input string tag);
        chk(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.d0  = 8'h10;
        bus.d1  = 8'h21;
        bus.d2  = 8'h32;
        bus.d3  = 8'h43;

        // Reset held with all requests up: nothing granted.
        step(); step(); step();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'h0);

        // Release: requester 0 has first priority.
        rst_n = 1'b1;
        step();
        chk("first_gnt", 32'(bus.gnt), 32'h1);
        chk("first_sel", 32'(bus.sel), 32'h0);

        // Drop in the grant cycle: no capture, grant withdrawn.
        bus.req = 4'b0000;
        step();
        chk("drop_gnt", 32'(bus.gnt), 32'h0);
        chk("drop_y_valid", 32'(bus.y_valid), 32'h0);
        chk("drop_sel_hold", 32'(bus.sel), 32'h0);

        // Single requester streaming.
        bus.req = 4'b0100;
        step();
        chk("stream_gnt", 32'(bus.gnt), 32'h4);
        chk("stream_sel", 32'(bus.sel), 32'h2);
        bus.d2 = 8'hA5; sb_q.push_back(8'hA5);
        step();
        chk("stream_valid0", 32'(bus.y_valid), 32'h1);
        bus.d2 = 8'h3C; sb_q.push_back(8'h3C);
        step();
        chk("stream_valid1", 32'(bus.y_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            wrd = 8'($urandom_range(0, 255));
            bus.d2 = wrd; sb_q.push_back(wrd);
            step();
            chk("stream_no_preempt", 32'(bus.gnt), 32'h4);
        end
        bus.req = 4'b0000;
        step();
        chk("stream_end_gnt", 32'(bus.gnt), 32'h0);
        chk("stream_end_sel", 32'(bus.sel), 32'h2);
        drain_check("stream_drain");

        // Contention between 0 and 1 (last=2, so 0 wins first).
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0010, 4'b0010, 4'b0010, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0001};
        bus.d0  = 8'hA0;
        bus.d1  = 8'hB1;
        bus.req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) sb_q.push_back(exp_gnt[k-1] == 4'b0001 ? 8'hA0 : 8'hB1);
            step();
            chk($sformatf("contend_gnt%0d", k), 32'(bus.gnt), 32'(exp_gnt[k]));
        end
        bus.req = 4'b0000;
        step();
        chk("contend_end_gnt", 32'(bus.gnt), 32'h0);
        drain_check("contend_drain");

        // Early release: owner 1 drops after 2 cycles, 3 waiting.
        bus.d1  = 8'h5A;
        bus.d3  = 8'hC3;
        bus.req = 4'b1010;
        step();
        chk("early_gnt1", 32'(bus.gnt), 32'h2);
        sb_q.push_back(8'h5A);
        step();
        chk("early_gnt1_hold", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1000;
        step();
        chk("early_handover", 32'(bus.gnt), 32'h8);
        chk("early_sel", 32'(bus.sel), 32'h3);

        // hold_cnt restarted at 1: owner 3 keeps 3 more cycles before 0 gets it.
        bus.req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(8'hC3);
            step();
            chk("restart_hold", 32'(bus.gnt), 32'h8);
        end
        sb_q.push_back(8'hC3);
        step();
        chk("wrap_to_0", 32'(bus.gnt), 32'h1);
        chk("wrap_sel0", 32'(bus.sel), 32'h0);

        // Requester 0 releases: 3 wins.
        bus.req = 4'b1000;
        step();
        chk("wrap_to_3", 32'(bus.gnt), 32'h8);

        // Hand to 1, capture a word, then reset between edges.
        bus.req = 4'b0010;
        bus.d1  = 8'h77;
        step();
        chk("pre_reset_gnt", 32'(bus.gnt), 32'h2);
        sb_q.push_back(8'h77);
        step();
        chk("pre_reset_valid", 32'(bus.y_valid), 32'h1);
        drain_check("pre_reset_drain");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'h0);
        chk("async_sel", 32'(bus.sel), 32'h0);
        chk("async_y", 32'(bus.y), 32'h0);
        chk("async_y_valid", 32'(bus.y_valid), 32'h0);
        bus.req = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
